// File: rtl/c432_key_pkg.sv
// c432_key_pkg: shared widths, frame size, FSM states and lockout limit for the c432 key loader (LOCKED exists only with C432_KEY_LOCKOUT_EN)
package c432_key_pkg;
  localparam int P_W_DEF = 32;
  localparam int X_W_DEF = 11;
  localparam int FRAME_W = P_W_DEF + X_W_DEF + 1;
  localparam int LOCKOUT_LIMIT = 3;
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOADED,
    ERROR
`ifdef C432_KEY_LOCKOUT_EN
    , LOCKED
`endif
  } state_t;
endpackage

// File: rtl/c432_key_shreg.sv
// c432_key_shreg: serial key capture register with bit counter and running even-parity accumulator
module c432_key_shreg
  import c432_key_pkg::*;
#(
  parameter int FW = FRAME_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          sdi,
  output logic [FW-2:0] data,
  output logic          par,
  output logic          done
);
  localparam int CW = $clog2(FW);
  logic [CW-1:0] cnt;
  assign done = en && (cnt == CW'(FW - 1));
  // capture data bits by position; the final (parity) bit only feeds the accumulator and the counter holds at the last index
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      data <= '0;
      par  <= 1'b0;
    end else if (en) begin
      if (!done) begin
        data[cnt] <= sdi;
        cnt       <= cnt + 1'b1;
      end
      par <= par ^ sdi;
    end
  end
endmodule

// File: rtl/c432_key_loader.sv
// c432_key_loader: loads a parity-checked serial key frame into the c432 MUX/XOR key registers (optional lockout via C432_KEY_LOCKOUT_EN)
module c432_key_loader
  import c432_key_pkg::*;
#(
  parameter int P_W = P_W_DEF,
  parameter int X_W = X_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_start,
  input  logic           key_vld,
  input  logic           key_sdi,
  output logic [P_W-1:0] p,
  output logic [X_W-1:0] x,
  output logic           key_ready,
  output logic           key_err
);
  localparam int FW = P_W + X_W + 1;
  state_t            state;
  logic              start;
  logic              cap;
  logic              done;
  logic              par;
  logic [FW-2:0]     data;
`ifdef C432_KEY_LOCKOUT_EN
  logic [1:0]        fail_cnt;
  assign start = key_start && (state != LOCKED);
`else
  assign start = key_start;
`endif
  assign cap = (state == SHIFT) && key_vld && !key_start;
  c432_key_shreg #(.FW(FW)) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .en   (cap),
    .sdi  (key_sdi),
    .data (data),
    .par  (par),
    .done (done)
  );
  // frame sequencing; key outputs change only on reset, start, or entry to LOADED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      x         <= '0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
`ifdef C432_KEY_LOCKOUT_EN
      fail_cnt  <= '0;
`endif
    end else if (start) begin
      state     <= SHIFT;
      p         <= '0;
      x         <= '0;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      case (state)
        SHIFT: state <= done ? CHECK : SHIFT;
        CHECK: begin
          if (!par) begin
            state     <= LOADED;
            p         <= data[P_W-1:0];
            x         <= data[P_W +: X_W];
            key_ready <= 1'b1;
`ifdef C432_KEY_LOCKOUT_EN
            fail_cnt  <= '0;
`endif
          end else begin
            key_err  <= 1'b1;
`ifdef C432_KEY_LOCKOUT_EN
            state    <= (fail_cnt == 2'(LOCKOUT_LIMIT - 1)) ? LOCKED : ERROR;
            fail_cnt <= (fail_cnt == 2'd3) ? fail_cnt : fail_cnt + 1'b1;
`else
            state    <= ERROR;
`endif
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: randomized frame loading against a frame-level model (lockout expectations follow C432_KEY_LOCKOUT_EN)
module tb_c432_key_loader;
  import c432_key_pkg::*;
  localparam int PW = 32;
  localparam int XW = 11;
  localparam int FW = PW + XW + 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_start = 1'b0;
  logic          key_vld = 1'b0;
  logic          key_sdi = 1'b0;
  logic [PW-1:0] p;
  logic [XW-1:0] x;
  logic          key_ready;
  logic          key_err;
  int            total = 0;
  int            bad = 0;
  int            fails = 0;
  bit            locked = 1'b0;
  c432_key_loader #(.P_W(PW), .X_W(XW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_start(key_start),
    .key_vld  (key_vld),
    .key_sdi  (key_sdi),
    .p        (p),
    .x        (x),
    .key_ready(key_ready),
    .key_err  (key_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [FW-1:0] mk(input logic [PW-1:0] pv, input logic [XW-1:0] xv, input bit flip);
    mk = {(^{xv, pv}) ^ flip, xv, pv};
  endfunction
  task automatic do_reset;
    rst_n = 1'b0;
    key_start = 1'b1;
    key_vld = 1'b1;
    tick;
    rst_n = 1'b1;
    key_start = 1'b0;
    key_vld = 1'b0;
    fails = 0;
    locked = 1'b0;
    chk("rst_p", p, 0);
    chk("rst_x", x, 0);
    chk("rst_rdy", key_ready, 0);
    chk("rst_err", key_err, 0);
  endtask
  task automatic shift_bits(input logic [FW-1:0] f, input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      if (tog) begin
        key_vld = 1'b0;
        key_sdi = 1'($urandom);
        tick;
        chk("hold_p", p, 0);
      end
      key_vld = 1'b1;
      key_sdi = f[i];
      tick;
      chk("shift_p", p, 0);
      chk("shift_x", x, 0);
      chk("shift_rdy", key_ready, 0);
    end
    key_vld = 1'b0;
  endtask
  task automatic pulse_start;
    key_start = 1'b1;
    key_vld = 1'b1;
    key_sdi = 1'b1;
    tick;
    key_start = 1'b0;
    key_vld = 1'b0;
    chk("start_p", p, 0);
    chk("start_rdy", key_ready, 0);
    chk("start_err", key_err, locked);
  endtask
  task automatic load(input logic [FW-1:0] f, input bit tog);
    bit ok;
    bit loaded;
    ok = ((^f) == 1'b0);
    loaded = !locked && ok;
    pulse_start;
    shift_bits(f, FW, tog);
    tick;
    if (!locked) begin
      if (ok) fails = 0;
      else begin
        fails++;
`ifdef C432_KEY_LOCKOUT_EN
        if (fails >= LOCKOUT_LIMIT) locked = 1'b1;
`endif
      end
    end
    chk("ld_rdy", key_ready, loaded);
    chk("ld_err", key_err, !loaded);
    chk("ld_p", p, loaded ? f[PW-1:0] : '0);
    chk("ld_x", x, loaded ? f[FW-2:PW] : '0);
    for (int i = 0; i < 3; i++) begin
      key_vld = 1'($urandom);
      key_sdi = 1'($urandom);
      tick;
      chk("stable_p", p, loaded ? f[PW-1:0] : '0);
      chk("stable_rdy", key_ready, loaded);
    end
    key_vld = 1'b0;
  endtask
  initial begin
    logic [FW-1:0] f;
    do_reset;
    key_vld = 1'b1;
    key_sdi = 1'b1;
    tick;
    key_vld = 1'b0;
    chk("idle_rdy", key_ready, 0);
    chk("idle_err", key_err, 0);
    f = mk(32'hA5A5_0F0F, 11'h5A3, 1'b0);
    chk("par_bit", f[FW-1], 0);
    load(f, 1'b0);
    load(mk(32'hA5A5_0F0F, 11'h5A3, 1'b1), 1'b0);
    load(mk(32'hA5A5_0F0F, 11'h5A3, 1'b0), 1'b1);
    pulse_start;
    shift_bits(mk(32'h1234_5678, 11'h7FF, 1'b0), 21, 1'b0);
    load(mk(32'hFFFF_FFFF, 11'h000, 1'b0), 1'b0);
    do_reset;
    chk("rst_loaded_p", p, 0);
    pulse_start;
    shift_bits(mk(32'hDEAD_BEEF, 11'h155, 1'b0), 10, 1'b0);
    do_reset;
    load(mk(32'hDEAD_BEEF, 11'h155, 1'b0), 1'b0);
    do_reset;
    for (int i = 0; i < 3; i++) load(mk($urandom, 11'($urandom), 1'b1), 1'b0);
    load(mk(32'hCAFE_F00D, 11'h2AA, 1'b0), 1'b0);
    do_reset;
    load(mk(32'hCAFE_F00D, 11'h2AA, 1'b0), 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (locked && ($urandom_range(0, 1) == 0)) do_reset;
      load(mk($urandom, 11'($urandom), $urandom_range(0, 9) < 4), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
